// File: rtl/load_pkg.sv
// Shared definitions for the load unit: funct3 load encodings, FSM states
// and the decode helpers used when a load request is accepted.
package load_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // True for the five supported load encodings.
  function automatic logic funct3_legal(input logic [2:0] f3);
    case (f3)
      LB, LH, LW, LBU, LHU: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      LH, LHU: return off[0];
      LW:      return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Data-memory read bus between the load unit and the data memory.
//   mem_req    : one-cycle read request strobe (master -> slave)
//   mem_addr   : word-aligned read address      (master -> slave)
//   mem_rdata  : read data word                 (slave -> master)
//   mem_rvalid : mem_rdata valid this cycle     (slave -> master)
interface load_unit_if;
  import load_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rvalid;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_rvalid
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_rvalid
  );
endinterface

// File: rtl/load_extend.sv
// Combinational lane select and sign/zero extension of a memory word.
//   funct3 : load type (lb/lh/lw/lbu/lhu), anything else yields 0
//   off    : byte offset addr[1:0] within the word
//   word   : raw data word from memory
//   result : aligned, extended load result
module load_extend
  import load_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = word[{off[1], 4'b0000} +: 16];
    result   = '0;
    case (funct3)
      LB:      result = {{24{byte_sel[7]}}, byte_sel};
      LH:      result = {{16{half_sel[15]}}, half_sel};
      LW:      result = word;
      LBU:     result = {24'h000000, byte_sel};
      LHU:     result = {16'h0000, half_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load unit: accepts a load request, issues one word read to data memory,
// waits (bounded by TIMEOUT) for the read data and returns the aligned,
// extended result with a one-cycle done pulse.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : start request, sampled only while idle
//   funct3     : load type
//   addr       : byte address, sampled with load
//   mem        : data-memory read bus (master side)
//   busy       : unit is not idle
//   done       : one-cycle completion pulse
//   err        : qualifies done: misaligned, illegal funct3 or timeout
//   rdata      : load result, zero on error, held until the next completion
module load_unit
  import load_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  addr,
  load_unit_if.master      mem,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [XLEN-1:0]  rdata
);

  // Counts 0..TIMEOUT-1; one extra bit of headroom keeps it wrap-free.
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              mem_req_q, mem_req_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   ext_result;

  load_extend u_extend (
    .funct3 (f3_q),
    .off    (off_q),
    .word   (mem.mem_rdata),
    .result (ext_result)
  );

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    off_d      = off_q;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;

    case (state_q)
      IDLE: begin
        if (load) begin
          f3_d  = funct3;
          off_d = addr[1:0];
          if (!funct3_legal(funct3) || misaligned(funct3, addr[1:0])) begin
            // Rejected up front: finish immediately, never touch memory.
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = {addr[XLEN-1:2], 2'b00};
            cnt_d      = '0;
          end
        end
      end

      REQ: begin
        state_d = WAIT;
        cnt_d   = '0;
      end

      WAIT: begin
        // Data on the final allowed cycle still beats the timeout.
        if (mem.mem_rvalid) begin
          state_d    = DONE;
          done_d     = 1'b1;
          rdata_d    = ext_result;
          mem_addr_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = DONE;
          done_d     = 1'b1;
          err_d      = 1'b1;
          rdata_d    = '0;
          mem_addr_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d    = IDLE;
        mem_addr_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = rdata_q;

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;
  import load_pkg::*;

  localparam int unsigned TO = 15;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic        busy, done, err;
  logic [31:0] rdata;

  int vectors;
  int miscompares;

  load_unit_if mem_bus ();

  load_unit #(.TIMEOUT(TO)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .funct3 (funct3),
    .addr   (addr),
    .mem    (mem_bus),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .rdata  (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One load transaction. rv_at is the WAIT-cycle index (0 = first) on
  // which mem_rvalid is driven, or -1 for never. exp_req=0 means the load
  // must be rejected without a memory request.
  task automatic xact(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] word, input int rv_at, input bit pulse_load,
                      input logic exp_err, input logic [31:0] exp_rdata, input bit exp_req);
    int done_cyc;
    @(negedge clk);                       // cycle 0
    load = 1'b1; funct3 = f3; addr = a;
    @(negedge clk);                       // cycle 1
    load = 1'b0;
    if (!exp_req) begin
      check({tag, ".req"},   32'(mem_bus.mem_req), 32'd0);
      check({tag, ".done"},  32'(done), 32'd1);
      check({tag, ".err"},   32'(err), 32'(exp_err));
      check({tag, ".rdata"}, rdata, exp_rdata);
      @(negedge clk);
      check({tag, ".done_off"}, 32'(done), 32'd0);
      check({tag, ".busy_off"}, 32'(busy), 32'd0);
      check({tag, ".req2"},     32'(mem_bus.mem_req), 32'd0);
      return;
    end
    check({tag, ".req"},  32'(mem_bus.mem_req), 32'd1);
    check({tag, ".addr"}, mem_bus.mem_addr, {a[31:2], 2'b00});
    check({tag, ".busy"}, 32'(busy), 32'd1);
    done_cyc = (rv_at >= 0 && rv_at < int'(TO)) ? 3 + rv_at : 2 + int'(TO);
    for (int c = 2; c < done_cyc; c++) begin
      @(negedge clk);
      if (c == 2) check({tag, ".req_once"}, 32'(mem_bus.mem_req), 32'd0);
      check({tag, ".addr_hold"}, mem_bus.mem_addr, {a[31:2], 2'b00});
      check({tag, ".early_done"}, 32'(done), 32'd0);
      load = pulse_load && (c == 2);
      mem_bus.mem_rvalid = (c - 2 == rv_at);
      mem_bus.mem_rdata  = (c - 2 == rv_at) ? word : 32'hDEAD_BEEF;
    end
    @(negedge clk);                       // done cycle
    load = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    check({tag, ".done"},  32'(done), 32'd1);
    check({tag, ".err"},   32'(err), 32'(exp_err));
    check({tag, ".rdata"}, rdata, exp_rdata);
    check({tag, ".addr0"}, mem_bus.mem_addr, 32'd0);
    @(negedge clk);
    check({tag, ".done_off"}, 32'(done), 32'd0);
    check({tag, ".busy_off"}, 32'(busy), 32'd0);
    check({tag, ".rdata_hold"}, rdata, exp_rdata);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; load = 1'b0; funct3 = 3'b000; addr = 32'h0;
    mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.busy",  32'(busy), 32'd0);
    check("rst.done",  32'(done), 32'd0);
    check("rst.err",   32'(err), 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.req",   32'(mem_bus.mem_req), 32'd0);
    check("rst.addr",  mem_bus.mem_addr, 32'd0);

    // Stray rvalid while idle must not produce a completion.
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check("idle_rv.done",  32'(done), 32'd0);
    check("idle_rv.rdata", rdata, 32'd0);

    xact("lb_1003",   3'b000, 32'h0000_1003, 32'h80FF_FF7F, 0,  1'b0, 1'b0, 32'hFFFF_FF80, 1'b1);
    xact("lhu_2002",  3'b101, 32'h0000_2002, 32'hBEEF_1234, 1,  1'b0, 1'b0, 32'h0000_BEEF, 1'b1);
    xact("lh_2002",   3'b001, 32'h0000_2002, 32'hBEEF_1234, 1,  1'b0, 1'b0, 32'hFFFF_BEEF, 1'b1);
    xact("lbu_1001",  3'b100, 32'h0000_1001, 32'h80FF_FF7F, 0,  1'b0, 1'b0, 32'h0000_00FF, 1'b1);
    xact("lh_2000",   3'b001, 32'h0000_2000, 32'hBEEF_1234, 3,  1'b0, 1'b0, 32'h0000_1234, 1'b1);
    xact("lw_3001",   3'b010, 32'h0000_3001, 32'h0,         -1, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
    xact("lw_tmo",    3'b010, 32'h0000_4000, 32'h0,         -1, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
    xact("lw_last",   3'b010, 32'h0000_4000, 32'hCAFE_F00D, 14, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b1);
    xact("ill_011",   3'b011, 32'h0000_5000, 32'h0,         -1, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
    xact("lb_pulse",  3'b000, 32'h0000_1000, 32'h0000_007F, 2,  1'b1, 1'b0, 32'h0000_007F, 1'b1);
    xact("lhu_2001",  3'b101, 32'h0000_2001, 32'h0,         -1, 1'b0, 1'b1, 32'h0000_0000, 1'b0);

    // Reset mid-WAIT, then a late rvalid.
    @(negedge clk);
    load = 1'b1; funct3 = 3'b010; addr = 32'h0000_5000;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    check("rstw.busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstw.busy",  32'(busy), 32'd0);
    check("rstw.addr",  mem_bus.mem_addr, 32'd0);
    check("rstw.rdata", rdata, 32'd0);
    check("rstw.err",   32'(err), 32'd0);
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    check("rstw.late_done", 32'(done), 32'd0);
    @(negedge clk);
    check("rstw.late_done2", 32'(done), 32'd0);
    check("rstw.late_rdata", rdata, 32'd0);
    check("rstw.late_busy",  32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
